fir_mac_scheduler: RTL and testbench
====================================

FIR_MAC_SCHEDULER -- requirements
Module: fir_mac_scheduler

Interface
REQ-001 Parameters SHALL be one per line, as name, default, meaning:
- NUM_CH, 4, number of requesting sample channels.
- TAPS, 16, filter length; must be even.
- MAC_LAT, 2, cycles from pair issue to accumulated product.
REQ-002 Derived constants SHALL be PAIRS = TAPS/2, CHW = clog2(NUM_CH) and PW = clog2(PAIRS).
REQ-003 Ports SHALL be one per line, as name, direction, width, meaning:
- clk, in, 1, the single clock.
- rst, in, 1, synchronous active-high reset.
- in_valid, in, NUM_CH, per-channel new-sample request.
- in_ready, out, NUM_CH, per-channel sample accept, one-hot or zero.
- shift_en, out, 1, shift the selected channel's delay line.
- sel_ch, out, CHW, channel that owns the MAC engine.
- pair_idx, out, PW, symmetric tap pair index and coefficient select.
- mac_en, out, 1, multiply-accumulate this pair.
- acc_clr, out, 1, start a new accumulation with this pair.
- out_valid, out, 1, filter result of out_ch is ready.
- out_ch, out, CHW, channel tag for the result.
- out_ready, in, 1, downstream accepts the result.
- busy, out, 1, high in every state except IDLE.
REQ-004 There SHALL be one clock, clk, and reset rst SHALL be synchronous and active-high.

Function
REQ-005 The FSM SHALL have exactly four states: IDLE, RUN, DRAIN and DONE.
REQ-006 In IDLE with any in_valid high, grant g SHALL be the first set bit searched round-robin from (last_grant+1) mod NUM_CH.
REQ-007 In the grant cycle, in_ready[g] and shift_en SHALL be 1 and sel_ch SHALL equal g; this is a combinational decode of the state and in_valid.
REQ-008 The grant cycle SHALL register last_grant <= g and SHALL move to RUN.
REQ-009 in_ready SHALL be all-zero outside the IDLE grant cycle, and in_valid SHALL be ignored in RUN, DRAIN and DONE.
REQ-010 In IDLE with no in_valid, all outputs SHALL be 0 and the FSM SHALL stay in IDLE.
REQ-011 RUN SHALL last exactly PAIRS cycles with mac_en=1 and pair_idx counting 0..PAIRS-1; acc_clr SHALL be 1 only when pair_idx=0.
REQ-012 At pair_idx=PAIRS-1, RUN SHALL move to DRAIN, and pair_idx SHALL wrap to 0.
REQ-013 DRAIN SHALL last exactly MAC_LAT cycles with mac_en=0, then move to DONE.
REQ-014 DONE SHALL hold out_valid=1 and out_ch=last_grant until out_ready=1; in that cycle it SHALL move to IDLE.
REQ-015 out_valid SHALL never drop before acceptance.
REQ-016 Latency: a grant at cycle T SHALL give first out_valid at T+PAIRS+MAC_LAT+1, which is T+11 at defaults.
REQ-017 With out_ready tied high, the minimum grant-to-grant period SHALL be PAIRS+MAC_LAT+2 cycles, which is 12 at defaults.
REQ-018 sel_ch SHALL hold last_grant throughout RUN, DRAIN and DONE.
REQ-019 If several in_valid bits are held high, channels SHALL be served strictly in rotation, with no channel starved.
REQ-020 A channel dropping in_valid before its grant SHALL simply be skipped.
REQ-021 sel_ch, pair_idx, mac_en, acc_clr, out_valid, out_ch and busy SHALL be registered or decoded from registered state only.

Reset
REQ-022 When rst=1, the next state SHALL be IDLE, with pair counter 0, drain counter 0 and last_grant=NUM_CH-1, so channel 0 has first priority.
REQ-023 During and after reset, every output SHALL be 0.
REQ-024 Reset in RUN, DRAIN or DONE SHALL abandon the operation, with no out_valid and no further mac_en for it.
REQ-025 rst SHALL take priority over every handshake in the same cycle.

Structure
REQ-026 Package fir_sched_pkg SHALL hold the state enum (IDLE, RUN, DRAIN, DONE) and the default values of NUM_CH, TAPS and MAC_LAT.
REQ-027 Round-robin grant logic SHALL be one sub-module, rr_arbiter (inputs req and last_grant, outputs one-hot grant, grant index and any_req).
REQ-028 Delay lines, coefficient ROM, adder, multiplier and accumulator SHALL stay outside this block.

Verification
REQ-029 Single request: in_valid=4'b0001 for one grant, out_ready=1 -> in_ready[0] and shift_en at T, mac_en T+1..T+8 with pair_idx 0..7, acc_clr only at T+1, out_valid with out_ch=0 at T+11, busy 0 at T+12.
REQ-030 All channels requesting continuously, out_ready=1 -> grants in order 0,1,2,3,0,1 every 12 cycles, with exactly one in_ready bit per grant.
REQ-031 Backpressure: out_ready=0 for 5 cycles after out_valid -> out_valid and out_ch held stable for 5 cycles, no in_ready meanwhile, and the next grant one cycle after acceptance.
REQ-032 Skip: in_valid=4'b1010 with last_grant=1 -> next grant 3, then 1.
REQ-033 Reset mid-RUN at pair_idx=4 -> the next cycle shows all outputs 0, no out_valid follows, and the next grant with in_valid=4'b1111 is channel 0.
REQ-034 Parameter sweep TAPS=8, MAC_LAT=3 -> RUN lasts 4 cycles, DRAIN 3 cycles, out_valid at T+8.

Source files
------------

// File: rtl/fir_sched_pkg.sv
// Shared types and defaults for the FIR MAC scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
// Contents: FSM state enum, default parameter values, width helper.
package fir_sched_pkg;

  localparam int DEF_NUM_CH  = 4;
  localparam int DEF_TAPS    = 16;
  localparam int DEF_MAC_LAT = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } sched_state_t;

  // clog2 that never returns 0, so a degenerate parameter value still
  // yields a legal one-bit vector.
  function automatic int safe_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fir_mac_scheduler_rr_arbiter.sv
// Round-robin arbiter: picks the first requester after last_grant.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when a grant is consumed.
// Ports: req (per-channel request), last_grant (index of the previous winner),
//        grant (one-hot winner), grant_idx (winner index), any_req (OR of req).
module rr_arbiter
  import fir_sched_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int CHW    = safe_clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CHW-1:0]    last_grant,
  output logic [NUM_CH-1:0] grant,
  output logic [CHW-1:0]    grant_idx,
  output logic              any_req
);

  // Scan starting one past the previous winner and wrapping; the previous
  // winner itself is visited last, which is what guarantees rotation.
  always_comb begin : search
    logic           found;
    logic [CHW-1:0] cand;
    grant     = '0;
    grant_idx = '0;
    any_req   = |req;
    found     = 1'b0;
    cand      = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      cand = CHW'((int'(last_grant) + i) % NUM_CH);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/fir_mac_scheduler.sv
// Schedules one shared symmetric-FIR MAC engine across NUM_CH sample channels.
// Latency: grant at T -> MAC pairs T+1..T+PAIRS, result valid at T+PAIRS+MAC_LAT+1.
// Backpressure: result held in DONE until out_ready; no new grant until accepted.
// Ports: clk/rst (sync active-high); in_valid/in_ready per-channel sample handshake;
//        shift_en/sel_ch delay-line control; pair_idx/mac_en/acc_clr MAC control;
//        out_valid/out_ch/out_ready result handshake; busy = not IDLE.
module fir_mac_scheduler
  import fir_sched_pkg::*;
#(
  parameter  int NUM_CH  = DEF_NUM_CH,
  parameter  int TAPS    = DEF_TAPS,
  parameter  int MAC_LAT = DEF_MAC_LAT,
  localparam int PAIRS   = TAPS / 2,
  localparam int CHW     = safe_clog2(NUM_CH),
  localparam int PW      = safe_clog2(PAIRS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] in_valid,
  output logic [NUM_CH-1:0] in_ready,
  output logic              shift_en,
  output logic [CHW-1:0]    sel_ch,
  output logic [PW-1:0]     pair_idx,
  output logic              mac_en,
  output logic              acc_clr,
  output logic              out_valid,
  output logic [CHW-1:0]    out_ch,
  input  logic              out_ready,
  output logic              busy
);

  localparam int DW = safe_clog2(MAC_LAT);

  sched_state_t state, next_state;

  logic [PW-1:0]     pair_cnt;
  logic [DW-1:0]     drain_cnt;
  logic [CHW-1:0]    last_grant;

  logic [NUM_CH-1:0] arb_grant;
  logic [CHW-1:0]    arb_idx;
  logic              arb_any;

  logic              pair_last;
  logic              drain_last;
  logic              grant_fire;

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .CHW    (CHW)
  ) u_arb (
    .req        (in_valid),
    .last_grant (last_grant),
    .grant      (arb_grant),
    .grant_idx  (arb_idx),
    .any_req    (arb_any)
  );

  assign pair_last  = (pair_cnt == PW'(PAIRS - 1));
  assign drain_last = (drain_cnt == DW'(MAC_LAT - 1));

  // A grant is only handed out from IDLE, and reset vetoes it in the same
  // cycle so no sample is popped that the engine will never process.
  assign grant_fire = (state == IDLE) && arb_any && !rst;

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Counters and grant history. last_grant resets to the top channel so the
  // first search after reset starts at channel 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      pair_cnt   <= '0;
      drain_cnt  <= '0;
      last_grant <= CHW'(NUM_CH - 1);
    end else begin
      if (grant_fire) begin
        last_grant <= arb_idx;
      end
      if (state == RUN) begin
        pair_cnt <= pair_last ? '0 : pair_cnt + 1'b1;
      end
      if (state == DRAIN) begin
        drain_cnt <= drain_last ? '0 : drain_cnt + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (arb_any)    next_state = RUN;
      RUN:   if (pair_last)  next_state = DRAIN;
      DRAIN: if (drain_last) next_state = DONE;
      DONE:  if (out_ready)  next_state = IDLE;
      default:               next_state = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Output decode
  // ---------------------------------------------------------------------
  always_comb begin
    in_ready  = '0;
    shift_en  = 1'b0;
    sel_ch    = '0;
    pair_idx  = '0;
    mac_en    = 1'b0;
    acc_clr   = 1'b0;
    out_valid = 1'b0;
    out_ch    = '0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        // The grant cycle is the only place in_valid reaches the outputs.
        if (grant_fire) begin
          in_ready = arb_grant;
          shift_en = 1'b1;
          sel_ch   = arb_idx;
        end
      end
      RUN: begin
        busy     = 1'b1;
        sel_ch   = last_grant;
        pair_idx = pair_cnt;
        mac_en   = 1'b1;
        acc_clr  = (pair_cnt == '0);
      end
      DRAIN: begin
        busy   = 1'b1;
        sel_ch = last_grant;
      end
      DONE: begin
        busy      = 1'b1;
        sel_ch    = last_grant;
        out_valid = 1'b1;
        out_ch    = last_grant;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Protocol properties
  // ---------------------------------------------------------------------
  a_ready_onehot0: assert property (@(posedge clk) $onehot0(in_ready));

  a_ready_only_idle: assert property (@(posedge clk) (in_ready != '0) |-> !busy);

  a_result_held: assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_ch)));

  a_mac_implies_busy: assert property (@(posedge clk) mac_en |-> busy);

endmodule

// File: tb/tb_fir_mac_scheduler.sv
// Self-checking bench for fir_mac_scheduler: default instance plus a
// TAPS=8/MAC_LAT=3 instance driven by the same stimulus, both checked every
// cycle against a transaction-timeline model, plus directed literal checks.
module tb_fir_mac_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] in_valid = 4'b0;
  logic       out_ready = 1'b0;

  logic [3:0] u0_in_ready, u1_in_ready;
  logic       u0_shift_en, u1_shift_en;
  logic [1:0] u0_sel_ch, u1_sel_ch;
  logic [2:0] u0_pair_idx;
  logic [1:0] u1_pair_idx;
  logic       u0_mac_en, u1_mac_en;
  logic       u0_acc_clr, u1_acc_clr;
  logic       u0_out_valid, u1_out_valid;
  logic [1:0] u0_out_ch, u1_out_ch;
  logic       u0_busy, u1_busy;

  int checks = 0;
  int errors = 0;
  int model_prints = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  fir_mac_scheduler #(.NUM_CH(4), .TAPS(16), .MAC_LAT(2)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(u0_in_ready),
    .shift_en(u0_shift_en), .sel_ch(u0_sel_ch), .pair_idx(u0_pair_idx),
    .mac_en(u0_mac_en), .acc_clr(u0_acc_clr), .out_valid(u0_out_valid),
    .out_ch(u0_out_ch), .out_ready(out_ready), .busy(u0_busy)
  );

  fir_mac_scheduler #(.NUM_CH(4), .TAPS(8), .MAC_LAT(3)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(u1_in_ready),
    .shift_en(u1_shift_en), .sel_ch(u1_sel_ch), .pair_idx(u1_pair_idx),
    .mac_en(u1_mac_en), .acc_clr(u1_acc_clr), .out_valid(u1_out_valid),
    .out_ch(u1_out_ch), .out_ready(out_ready), .busy(u1_busy)
  );

  function automatic logic [20:0] pk(input logic [3:0] ir, input logic se,
                                     input logic [1:0] sc, input logic [7:0] pi,
                                     input logic me, input logic ac, input logic ov,
                                     input logic [1:0] oc, input logic bz);
    return {ir, se, sc, pi, me, ac, ov, oc, bz};
  endfunction

  wire [20:0] act0 = pk(u0_in_ready, u0_shift_en, u0_sel_ch, {5'd0, u0_pair_idx},
                        u0_mac_en, u0_acc_clr, u0_out_valid, u0_out_ch, u0_busy);
  wire [20:0] act1 = pk(u1_in_ready, u1_shift_en, u1_sel_ch, {6'd0, u1_pair_idx},
                        u1_mac_en, u1_acc_clr, u1_out_valid, u1_out_ch, u1_busy);

  // Model: each instance is either idle or serving one job granted at
  // cycle m_t0; outputs follow from the offset since that grant.
  int m_pairs[2] = '{8, 4};
  int m_lat[2]   = '{2, 3};
  int m_last[2]  = '{3, 3};
  bit m_act[2]   = '{0, 0};
  int m_t0[2]    = '{0, 0};

  always @(negedge clk) begin : model_cmp
    logic [3:0]  e_ir;
    logic        e_se, e_me, e_ac, e_ov, e_bz, found;
    logic [1:0]  e_sc, e_oc;
    logic [7:0]  e_pi;
    logic [20:0] exp_v, act_v;
    int g, off, c;
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        e_ir = 0; e_se = 0; e_sc = 0; e_pi = 0; e_me = 0; e_ac = 0;
        e_ov = 0; e_oc = 0; e_bz = 0; g = -1; found = 0;
        if (!m_act[d]) begin
          if (!rst && in_valid != 4'b0) begin
            for (int k = 1; k <= 4; k++) begin
              c = (m_last[d] + k) % 4;
              if (!found && in_valid[c]) begin
                found = 1'b1;
                g = c;
              end
            end
            e_ir = 4'(1 << g);
            e_se = 1'b1;
            e_sc = 2'(g);
          end
        end else begin
          off  = cyc - m_t0[d];
          e_bz = 1'b1;
          e_sc = 2'(m_last[d]);
          if (off <= m_pairs[d]) begin
            e_me = 1'b1;
            e_pi = 8'(off - 1);
            e_ac = (off == 1);
          end else if (off > m_pairs[d] + m_lat[d]) begin
            e_ov = 1'b1;
            e_oc = 2'(m_last[d]);
          end
        end
        exp_v = pk(e_ir, e_se, e_sc, e_pi, e_me, e_ac, e_ov, e_oc, e_bz);
        act_v = (d == 0) ? act0 : act1;
        checks++;
        if (act_v !== exp_v) begin
          errors++;
          if (model_prints < 30) begin
            model_prints++;
            $display("FAIL model_cmp dut%0d cycle %0d: got %h expected %h", d, cyc, act_v, exp_v);
          end
        end
        if (rst) begin
          m_act[d]  = 1'b0;
          m_last[d] = 3;
        end else if (!m_act[d] && g >= 0) begin
          m_act[d]  = 1'b1;
          m_last[d] = g;
          m_t0[d]   = cyc;
        end else if (m_act[d] && e_ov && out_ready) begin
          m_act[d] = 1'b0;
        end
      end
    end
    cyc++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic do_reset;
    rst = 1'b1;
    in_valid = 4'b0;
    tick;
    tick;
    rst = 1'b0;
  endtask

  function automatic int oh2idx(input logic [3:0] v);
    int r;
    r = -1;
    for (int i = 0; i < 4; i++) if (v[i]) r = i;
    return r;
  endfunction

  int gidx[6];
  int gcyc[6];
  int n, w;

  initial begin
    // Reset: outputs zero even with requests pending.
    rst = 1'b1; in_valid = 4'hF; out_ready = 1'b1;
    tick;
    chk_en = 1'b1;
    tick;
    chk("reset_outs_dut0", int'(act0), 0);
    chk("reset_outs_dut1", int'(act1), 0);

    // Single request on channel 0, grant at T.
    rst = 1'b0; in_valid = 4'b0001; #1;
    chk("single_in_ready", int'(u0_in_ready), 1);
    chk("single_shift_en", int'(u0_shift_en), 1);
    chk("single_sel_ch", int'(u0_sel_ch), 0);
    tick; in_valid = 4'b0; #1;                          // T+1
    chk("single_mac_t1", int'(u0_mac_en), 1);
    chk("single_pair_t1", int'(u0_pair_idx), 0);
    chk("single_clr_t1", int'(u0_acc_clr), 1);
    chk("sweep_pair_t1", int'(u1_pair_idx), 0);
    repeat (3) tick;                                    // T+4
    chk("sweep_mac_t4", int'(u1_mac_en), 1);
    chk("sweep_pair_t4", int'(u1_pair_idx), 3);
    tick;                                               // T+5
    chk("sweep_drain_t5", int'(u1_mac_en), 0);
    chk("single_clr_t5", int'(u0_acc_clr), 0);
    repeat (3) tick;                                    // T+8
    chk("single_pair_t8", int'(u0_pair_idx), 7);
    chk("sweep_valid_t8", int'(u1_out_valid), 1);
    tick;                                               // T+9
    chk("single_mac_t9", int'(u0_mac_en), 0);
    chk("sweep_idle_t9", int'(u1_busy), 0);
    repeat (2) tick;                                    // T+11
    chk("single_valid_t11", int'(u0_out_valid), 1);
    chk("single_ch_t11", int'(u0_out_ch), 0);
    tick;                                               // T+12
    chk("single_busy_t12", int'(u0_busy), 0);

    // All channels requesting continuously.
    do_reset;
    in_valid = 4'hF; out_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 100 && n < 6; c++) begin
      #1;
      if (u0_in_ready != 4'b0) begin
        chk("rr_onehot", $countones(u0_in_ready), 1);
        gidx[n] = oh2idx(u0_in_ready);
        gcyc[n] = c;
        n++;
      end
      tick;
    end
    chk("rr_grant_count", n, 6);
    for (int k = 0; k < 6; k++) begin
      chk("rr_order", gidx[k], k % 4);
      if (k > 0) chk("rr_period", gcyc[k] - gcyc[k-1], 12);
    end

    // Backpressure in DONE.
    do_reset;
    in_valid = 4'hF; out_ready = 1'b0;
    for (w = 0; w < 40 && !u0_out_valid; w++) tick;
    chk("bp_seen_valid", int'(u0_out_valid), 1);
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid_held", int'(u0_out_valid), 1);
      chk("bp_ch_held", int'(u0_out_ch), 0);
      chk("bp_no_ready", int'(u0_in_ready), 0);
      tick;
    end
    out_ready = 1'b1; #1;
    chk("bp_accept_valid", int'(u0_out_valid), 1);
    tick;
    chk("bp_next_grant", int'(u0_in_ready), 2);

    // Skip of non-requesting channels.
    do_reset;
    out_ready = 1'b1;
    in_valid = 4'b0010; #1;
    chk("skip_first", int'(u0_in_ready), 2);
    tick; in_valid = 4'b0;
    for (w = 0; w < 40 && u0_busy; w++) tick;
    chk("skip_idle", int'(u0_busy), 0);
    in_valid = 4'b1010; #1;
    chk("skip_grant3", int'(u0_in_ready), 8);
    tick;
    for (w = 0; w < 40 && u0_in_ready == 4'b0; w++) tick;
    chk("skip_grant1", int'(u0_in_ready), 2);

    // Reset in the middle of RUN.
    do_reset;
    in_valid = 4'hF; out_ready = 1'b1;
    for (w = 0; w < 40 && !(u0_mac_en && u0_pair_idx == 3'd4); w++) tick;
    chk("mid_run_reached", int'(u0_pair_idx), 4);
    rst = 1'b1;
    tick;
    rst = 1'b0; in_valid = 4'b0; #1;
    chk("mid_rst_outs_dut0", int'(act0), 0);
    chk("mid_rst_outs_dut1", int'(act1), 0);
    repeat (3) begin
      tick;
      chk("mid_rst_no_valid", int'(u0_out_valid), 0);
      chk("mid_rst_no_mac", int'(u0_mac_en), 0);
    end
    in_valid = 4'hF; #1;
    chk("mid_rst_regrant", int'(u0_in_ready), 1);
    tick;

    // Randomized traffic, checked by the model every cycle.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) in_valid = 4'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 149) == 0);
      tick;
    end
    rst = 1'b0; out_ready = 1'b1; in_valid = 4'b0;
    repeat (30) tick;

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
